shift_cmd_seq: RTL

SHIFT_CMD_SEQ -- requirements
Module: shift_cmd_seq

---
 rtl/shift_cmd_seq.sv | 109 ++++++++++
 1 files changed

// File: rtl/shift_cmd_seq.sv
// rtl/shift_cmd_seq.sv - command FIFO feeding a repeat-count issue sequencer for a shift register
//
// Ports:
//   clk             - single clock, rising edge
//   reset           - asynchronous active-low reset
//   cmd_valid/ready - command handshake; push when both high
//   cmd_op/data/count - command fields {op, data, repeat count (issues count+1 cycles)}
//   flush           - synchronous abort of queued and active commands
//   enable          - downstream shift-register enable
//   shift_direction - op code of the command being issued (held while idle)
//   data_in         - data of the command being issued (held while idle)
//   done            - one-cycle pulse on the last issue cycle of a command
//   busy            - command active or FIFO non-empty
//   fifo_level      - current FIFO occupancy
module shift_cmd_seq #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [7:0]               cmd_data,
    input  logic [2:0]               cmd_count,
    input  logic                     flush,
    output logic                     enable,
    output logic [2:0]               shift_direction,
    output logic [7:0]               data_in,
    output logic                     done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t          state;
    logic [13:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [2:0]      remaining;
    logic [13:0]     head;
    logic            push;
    logic            pop;

    // A full FIFO never accepts, even when a pop happens on the same edge.
    assign cmd_ready = (fifo_level != LW'(DEPTH)) && !flush;
    assign push      = cmd_valid && cmd_ready;
    // Pop when idle, or on the last issue cycle so the next command follows without a gap.
    assign pop       = !flush && (fifo_level != '0) && ((state == IDLE) || (remaining == 3'd0));
    assign head      = mem[rd_ptr];
    assign busy      = (state == ISSUE) || (fifo_level != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_op, cmd_data, cmd_count};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fifo_level      <= '0;
            remaining       <= '0;
            enable          <= 1'b0;
            done            <= 1'b0;
            shift_direction <= '0;
            data_in         <= '0;
        end else if (flush) begin
            // Held shift_direction/data_in are intentionally left untouched.
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            enable     <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_level <= fifo_level + LW'(push) - LW'(pop);

            if (pop) begin
                state           <= ISSUE;
                enable          <= 1'b1;
                shift_direction <= head[13:11];
                data_in         <= head[10:3];
                remaining       <= head[2:0];
                done            <= (head[2:0] == 3'd0);
            end else if ((state == ISSUE) && (remaining != 3'd0)) begin
                remaining <= remaining - 3'd1;
                // done is registered, so it rises together with remaining reaching zero.
                done      <= (remaining == 3'd1);
            end else begin
                state  <= IDLE;
                enable <= 1'b0;
                done   <= 1'b0;
            end
        end
    end

endmodule
